// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the five-stage core: register write/clear enables, PC enable,
// memory-completion latching, load-use bubbles, branch/jump flushes and HALT holding.
module hazard_ctrl (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        exmem_dREN,
    input  logic        exmem_dWEN,
    input  logic        idex_dREN,
    input  logic [4:0]  idex_rt,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        ifid_uses_rt,
    input  logic        branch_taken,
    input  logic        jump_id,
    input  logic        halt_wb,
    output logic        pcWEN,
    output logic        ifid_W,
    output logic        idex_W,
    output logic        exmem_W,
    output logic        memwb_W,
    output logic        ifid_RST,
    output logic        idex_RST,
    output logic        exmem_RST,
    output logic        memwb_RST,
    output logic        halt,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t state, next_state;
    logic   i_done, d_done;
    logic   mem_op, i_ok, d_ok, advance, load_use;
    logic   stall_inc, flush_inc;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign mem_op   = exmem_dREN | exmem_dWEN;
    assign i_ok     = ihit | i_done;
    assign d_ok     = ~mem_op | dhit | d_done;
    // nRST gates advance so every enable is forced low while reset is held
    assign advance  = nRST & (state == RUN) & i_ok & d_ok;
    assign load_use = idex_dREN & (idex_rt != 5'd0) &
                      ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt)));

    always_comb begin
        next_state = state;
        pcWEN      = 1'b0;
        ifid_W     = 1'b0;
        idex_W     = 1'b0;
        exmem_W    = 1'b0;
        memwb_W    = 1'b0;
        ifid_RST   = 1'b0;
        idex_RST   = 1'b0;
        exmem_RST  = 1'b0;
        memwb_RST  = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;

        if (state == RUN && nRST && !advance) begin
            stall_inc = 1'b1;
        end

        if (advance) begin
            if (halt_wb) begin
                ifid_W     = 1'b1;
                idex_W     = 1'b1;
                exmem_W    = 1'b1;
                memwb_W    = 1'b1;
                next_state = HALTED;
            end else if (branch_taken) begin
                pcWEN     = 1'b1;
                memwb_W   = 1'b1;
                ifid_RST  = 1'b1;
                idex_RST  = 1'b1;
                exmem_RST = 1'b1;
                flush_inc = 1'b1;
            end else if (load_use) begin
                // hold PC and IF/ID, drop a bubble into EX
                idex_RST  = 1'b1;
                exmem_W   = 1'b1;
                memwb_W   = 1'b1;
                stall_inc = 1'b1;
            end else if (jump_id) begin
                pcWEN     = 1'b1;
                ifid_RST  = 1'b1;
                idex_W    = 1'b1;
                exmem_W   = 1'b1;
                memwb_W   = 1'b1;
                flush_inc = 1'b1;
            end else begin
                pcWEN   = 1'b1;
                ifid_W  = 1'b1;
                idex_W  = 1'b1;
                exmem_W = 1'b1;
                memwb_W = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= RUN;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            halt      <= 1'b0;
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            state <= next_state;
            // completions arriving ahead of their partner are held until the pipe moves
            if (advance) begin
                i_done <= 1'b0;
                d_done <= 1'b0;
            end else if (state == RUN) begin
                if (ihit)
                    i_done <= 1'b1;
                if (dhit && mem_op)
                    d_done <= 1'b1;
            end
            if (next_state == HALTED)
                halt <= 1'b1;
            if (stall_inc)
                stall_cnt <= sat_inc(stall_cnt);
            if (flush_inc)
                flush_cnt <= sat_inc(flush_cnt);
        end
    end

endmodule
